// File: rtl/rf_pkg.sv
// rf_pkg: shared constants and types for the multiport register file.
//   RF_DEF_WIDTH / RF_DEF_DEPTH / RF_DEF_NRD : default geometry
//   rf_state_t                               : soft-clear sweep states
package rf_pkg;

   localparam int RF_DEF_WIDTH = 16;
   localparam int RF_DEF_DEPTH = 16;
   localparam int RF_DEF_NRD   = 2;

   typedef enum logic {
      RF_IDLE  = 1'b0,
      RF_SWEEP = 1'b1
   } rf_state_t;

endpackage

// File: rtl/rf_read_port.sv
// rf_read_port: one combinational read port of the register file.
// Ports:
//   raddr            in  register address for this port
//   mem_flat         in  whole array, entry k at [k*WIDTH +: WIDTH]
//   busy             in  busy scoreboard, one bit per entry
//   we0/waddr0/wdata0, we1/waddr1/wdata1
//                    in  qualified same-cycle writes (already dropped when
//                        sweeping or targeting a hardwired entry 0)
//   rsv_en/rsv_addr  in  qualified same-cycle reservation
//   rdata            out read data with write bypass (port 1 over port 0)
//   rbusy            out busy flag of the addressed entry
module rf_read_port
   import rf_pkg::*;
#(
   parameter  int WIDTH   = RF_DEF_WIDTH,
   parameter  int DEPTH   = RF_DEF_DEPTH,
   parameter  int ZERO_R0 = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic [AW-1:0]          raddr,
   input  logic [DEPTH*WIDTH-1:0] mem_flat,
   input  logic [DEPTH-1:0]       busy,
   input  logic                   we0,
   input  logic [AW-1:0]          waddr0,
   input  logic [WIDTH-1:0]       wdata0,
   input  logic                   we1,
   input  logic [AW-1:0]          waddr1,
   input  logic [WIDTH-1:0]       wdata1,
   input  logic                   rsv_en,
   input  logic [AW-1:0]          rsv_addr,
   output logic [WIDTH-1:0]       rdata,
   output logic                   rbusy
);

   logic wr_hit0;
   logic wr_hit1;
   logic rsv_hit;
   logic r0_sel;

   always_comb begin
      wr_hit0 = we0 && (waddr0 == raddr);
      wr_hit1 = we1 && (waddr1 == raddr);
      rsv_hit = rsv_en && (rsv_addr == raddr);
      r0_sel  = (ZERO_R0 != 0) && (raddr == '0);

      rdata = mem_flat[raddr*WIDTH +: WIDTH];
      rbusy = busy[raddr];

      if (wr_hit1) begin
         rdata = wdata1;
      end else if (wr_hit0) begin
         rdata = wdata0;
      end

      // A landing result retires the reservation, unless a new reservation
      // for the same entry arrives in the same cycle (that one wins).
      if ((wr_hit0 || wr_hit1) && !rsv_hit) begin
         rbusy = 1'b0;
      end

      if (r0_sel) begin
         rdata = '0;
         rbusy = 1'b0;
      end
   end

endmodule

// File: rtl/rf_multiport.sv
// rf_multiport: WIDTH x DEPTH register file with NRD combinational read
// ports, two bypassed write ports, a busy scoreboard and a soft-clear sweep.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   raddr / rdata / rbusy    read ports, port i at [i*AW], [i*WIDTH], [i]
//   wen0/waddr0/wdata0       write port 0
//   wen1/waddr1/wdata1       write port 1 (wins on address collision)
//   rsv_en/rsv_addr          mark an entry busy
//   clr_req                  start zeroing sweep (one entry per cycle)
//   clr_busy                 sweep in progress
module rf_multiport
   import rf_pkg::*;
#(
   parameter  int WIDTH   = RF_DEF_WIDTH,
   parameter  int DEPTH   = RF_DEF_DEPTH,
   parameter  int NRD     = RF_DEF_NRD,
   parameter  int ZERO_R0 = 1,
   localparam int AW      = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [NRD*AW-1:0]    raddr,
   output logic [NRD*WIDTH-1:0] rdata,
   output logic [NRD-1:0]       rbusy,
   input  logic                 wen0,
   input  logic [AW-1:0]        waddr0,
   input  logic [WIDTH-1:0]     wdata0,
   input  logic                 wen1,
   input  logic [AW-1:0]        waddr1,
   input  logic [WIDTH-1:0]     wdata1,
   input  logic                 rsv_en,
   input  logic [AW-1:0]        rsv_addr,
   input  logic                 clr_req,
   output logic                 clr_busy
);

   localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);

   rf_state_t              state_q;
   rf_state_t              state_d;
   logic [AW-1:0]          ptr_q;
   logic [WIDTH-1:0]       mem_q [DEPTH];
   logic [DEPTH-1:0]       busy_q;
   logic [DEPTH*WIDTH-1:0] mem_flat;
   logic                   sweeping;
   logic                   we0;
   logic                   we1;
   logic                   rsv;

   assign sweeping = (state_q == RF_SWEEP);
   assign clr_busy = sweeping;

   // Qualified requests: the sweep owns the array, and a hardwired entry 0
   // never takes data or reservations. Bypass uses these too, so it is
   // automatically disabled while sweeping.
   assign we0 = wen0   && !sweeping && !((ZERO_R0 != 0) && (waddr0   == '0));
   assign we1 = wen1   && !sweeping && !((ZERO_R0 != 0) && (waddr1   == '0));
   assign rsv = rsv_en && !sweeping && !((ZERO_R0 != 0) && (rsv_addr == '0));

   always_comb begin
      state_d = state_q;
      case (state_q)
         RF_IDLE:  if (clr_req) state_d = RF_SWEEP;
         RF_SWEEP: if (ptr_q == PTR_LAST) state_d = RF_IDLE;
         default:  state_d = RF_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RF_IDLE;
         ptr_q   <= '0;
      end else begin
         state_q <= state_d;
         // ptr idles at 0 so the first sweep cycle clears entry 0; it parks
         // at DEPTH-1 on the last sweep cycle instead of wrapping.
         if (!sweeping) begin
            ptr_q <= '0;
         end else if (ptr_q != PTR_LAST) begin
            ptr_q <= ptr_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         busy_q <= '0;
      end else if (sweeping) begin
         mem_q[ptr_q]  <= '0;
         busy_q[ptr_q] <= 1'b0;
      end else begin
         // Later assignments take precedence: port 1 over port 0, and a
         // reservation over the busy-clear of a same-cycle write.
         if (we0) begin
            mem_q[waddr0]  <= wdata0;
            busy_q[waddr0] <= 1'b0;
         end
         if (we1) begin
            mem_q[waddr1]  <= wdata1;
            busy_q[waddr1] <= 1'b0;
         end
         if (rsv) begin
            busy_q[rsv_addr] <= 1'b1;
         end
      end
   end

   for (genvar g = 0; g < DEPTH; g++) begin : g_flat
      assign mem_flat[g*WIDTH +: WIDTH] = mem_q[g];
   end

   for (genvar p = 0; p < NRD; p++) begin : g_rd
      rf_read_port #(
         .WIDTH   (WIDTH),
         .DEPTH   (DEPTH),
         .ZERO_R0 (ZERO_R0)
      ) u_rd (
         .raddr    (raddr[p*AW +: AW]),
         .mem_flat (mem_flat),
         .busy     (busy_q),
         .we0      (we0),
         .waddr0   (waddr0),
         .wdata0   (wdata0),
         .we1      (we1),
         .waddr1   (waddr1),
         .wdata1   (wdata1),
         .rsv_en   (rsv),
         .rsv_addr (rsv_addr),
         .rdata    (rdata[p*WIDTH +: WIDTH]),
         .rbusy    (rbusy[p])
      );
   end

endmodule
